fp_result_scoreboard: RTL and testbench

- Parametrised, self-checking scoreboard for the fp_unit verification environment; replaces the fixed 5-stage expected-value delay line with a FIFO of expected entries.
- Expected entries are pushed when an operation is issued and popped on each fp_unit result-valid pulse, so any or variable unit latency is tolerated.
- Results are compared with per-format canonical-NaN relaxation; the block keeps pass/fail counters, captures the first mismatch, and signals completion.

---
 rtl/fp_result_scoreboard.sv | 194 +++++++++++++++++++
 tb/tb_fp_result_scoreboard.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_result_scoreboard.sv
// Purpose : fp_unit result scoreboard. Expected entries queue in a FIFO and the head is
//           compared against each fp_unit result; pass/fail counts, first-failure capture,
//           and completion/halt status are kept.
// Latency : compare is combinational against the FIFO head; counters, stickies and
//           captures update on the following clock edge.
// Backpr. : o_exp_ready = !full && RUN. A push is also taken while full if the head
//           pops in the same cycle, so occupancy holds.
// Ports   : i_clock/i_reset_n (async, active-low); i_exp_* push side; i_dut_* result side;
//           o_pass_count/o_fail_count/o_fail/o_orphan/o_done status; o_cap_* first-failure
//           capture; o_level FIFO occupancy.
module fp_result_scoreboard #(
  parameter int DEPTH        = 8,   // power of two, >= 2
  parameter int XLEN         = 64,  // must be >= 64 (double-NaN test uses bits [63:0])
  parameter int CNT_WIDTH    = 32,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic                     i_clock,
  input  logic                     i_reset_n,
  input  logic                     i_exp_valid,
  output logic                     o_exp_ready,
  input  logic [XLEN-1:0]          i_exp_result,
  input  logic [4:0]               i_exp_flags,
  input  logic [1:0]               i_exp_fmt,
  input  logic                     i_exp_relax,
  input  logic                     i_exp_last,
  input  logic                     i_dut_ready,
  input  logic [XLEN-1:0]          i_dut_result,
  input  logic [4:0]               i_dut_flags,
  output logic [CNT_WIDTH-1:0]     o_pass_count,
  output logic [CNT_WIDTH-1:0]     o_fail_count,
  output logic                     o_fail,
  output logic                     o_orphan,
  output logic                     o_done,
  output logic [XLEN-1:0]          o_cap_expected,
  output logic [XLEN-1:0]          o_cap_result,
  output logic [4:0]               o_cap_flags_diff,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int            AW     = $clog2(DEPTH);
  localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_RUN, ST_HALT, ST_DONE} state_t;

  // Expected-entry storage (no reset needed: validity is tracked by the pointers/level)
  logic [XLEN-1:0] r_mem_result [DEPTH];
  logic [4:0]      r_mem_flags  [DEPTH];
  logic [1:0]      r_mem_fmt    [DEPTH];
  logic            r_mem_relax  [DEPTH];
  logic            r_mem_last   [DEPTH];

  state_t          r_state;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_level;
  logic [CNT_WIDTH-1:0] r_pass_count;
  logic [CNT_WIDTH-1:0] r_fail_count;
  logic            r_fail;
  logic            r_orphan;
  logic            r_done;
  logic [XLEN-1:0] r_cap_expected;
  logic [XLEN-1:0] r_cap_result;
  logic [4:0]      r_cap_flags_diff;

  logic            w_run;
  logic            w_full;
  logic            w_empty;
  logic            w_check;
  logic            w_pop;
  logic            w_push;
  logic            w_orphan_ev;
  logic            w_fail_ev;
  logic [XLEN-1:0] w_head_result;
  logic [4:0]      w_head_flags;
  logic [1:0]      w_head_fmt;
  logic            w_head_relax;
  logic            w_head_last;
  logic [XLEN-1:0] w_res_x;
  logic [4:0]      w_flags_x;
  logic            w_res_diff;
  logic            w_mismatch;

  assign w_run   = (r_state == ST_RUN);
  assign w_full  = (r_level == L_FULL);
  assign w_empty = (r_level == '0);

  assign o_exp_ready = !w_full && w_run;

  // No bypass: an entry pushed into an empty FIFO cannot serve a same-cycle result.
  assign w_check     = i_dut_ready && w_run;
  assign w_pop       = w_check && !w_empty;
  assign w_orphan_ev = w_check && w_empty;
  assign w_push      = i_exp_valid && w_run && (!w_full || w_pop);

  assign w_head_result = r_mem_result[r_rd_ptr];
  assign w_head_flags  = r_mem_flags[r_rd_ptr];
  assign w_head_fmt    = r_mem_fmt[r_rd_ptr];
  assign w_head_relax  = r_mem_relax[r_rd_ptr];
  assign w_head_last   = r_mem_last[r_rd_ptr];

  assign w_res_x   = i_dut_result ^ w_head_result;
  assign w_flags_x = i_dut_flags ^ w_head_flags;

  // Canonical-NaN relaxation: when the unit returns the canonical quiet NaN, only the
  // exponent field and the quiet bit must agree; payload and sign are free.
  always_comb begin
    w_res_diff = |w_res_x;
    if (w_head_fmt == 2'd0) begin
      if (w_head_relax && (i_dut_result[31:0] == 32'h7FC0_0000))
        w_res_diff = |w_res_x[30:22];
    end else begin
      if (w_head_relax && (i_dut_result[63:0] == 64'h7FF8_0000_0000_0000))
        w_res_diff = |w_res_x[62:51];
    end
  end

  assign w_mismatch = w_res_diff || (|w_flags_x);
  assign w_fail_ev  = (w_pop && w_mismatch) || w_orphan_ev;

  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_mem_result[r_wr_ptr] <= i_exp_result;
      r_mem_flags[r_wr_ptr]  <= i_exp_flags;
      r_mem_fmt[r_wr_ptr]    <= i_exp_fmt;
      r_mem_relax[r_wr_ptr]  <= i_exp_relax;
      r_mem_last[r_wr_ptr]   <= i_exp_last;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state          <= ST_RUN;
      r_wr_ptr         <= '0;
      r_rd_ptr         <= '0;
      r_level          <= '0;
      r_pass_count     <= '0;
      r_fail_count     <= '0;
      r_fail           <= 1'b0;
      r_orphan         <= 1'b0;
      r_done           <= 1'b0;
      r_cap_expected   <= '0;
      r_cap_result     <= '0;
      r_cap_flags_diff <= '0;
    end else begin
      // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase

      if (w_pop && !w_mismatch && !(&r_pass_count))
        r_pass_count <= r_pass_count + 1'b1;

      if (w_fail_ev) begin
        if (!(&r_fail_count)) r_fail_count <= r_fail_count + 1'b1;
        r_fail <= 1'b1;
        if (!r_fail) begin
          r_cap_expected   <= w_orphan_ev ? '0 : w_head_result;
          r_cap_result     <= i_dut_result;
          r_cap_flags_diff <= w_orphan_ev ? i_dut_flags : w_flags_x;
        end
      end

      if (w_orphan_ev) r_orphan <= 1'b1;

      case (r_state)
        ST_RUN: begin
          if (w_fail_ev && STOP_ON_FAIL) begin
            r_state <= ST_HALT;
            r_done  <= 1'b1;
          end else if (w_pop && w_head_last) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= r_state;  // HALT and DONE are left only through reset
      endcase
    end
  end

  assign o_pass_count     = r_pass_count;
  assign o_fail_count     = r_fail_count;
  assign o_fail           = r_fail;
  assign o_orphan         = r_orphan;
  assign o_done           = r_done;
  assign o_cap_expected   = r_cap_expected;
  assign o_cap_result     = r_cap_result;
  assign o_cap_flags_diff = r_cap_flags_diff;
  assign o_level          = r_level;

endmodule

// File: tb/tb_fp_result_scoreboard.sv
// Bench for fp_result_scoreboard: two instances (keep-going and stop-on-fail) share
// one stimulus stream and are both compared every cycle against a queue-based model.
// Counter width is kept small so saturation is reached.
module tb_fp_result_scoreboard;

  localparam int DEPTH = 8;
  localparam int XLEN  = 64;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  flg;
    logic [1:0]  fmt;
    logic        relax;
    logic        last;
  } ent_t;

  logic clk;
  logic rst_n;
  logic exp_vld;
  logic [63:0] exp_res;
  logic [4:0]  exp_flg;
  logic [1:0]  exp_fmt;
  logic        exp_relax;
  logic        exp_last;
  logic        dut_rdy;
  logic [63:0] dut_res;
  logic [4:0]  dut_flg;

  logic        rdy     [2];
  logic [CW-1:0] pass_c [2];
  logic [CW-1:0] fail_c [2];
  logic        failb   [2];
  logic        orph    [2];
  logic        done    [2];
  logic [63:0] cap_exp [2];
  logic [63:0] cap_res [2];
  logic [4:0]  cap_fd  [2];
  logic [3:0]  lvl     [2];

  int n_checks;
  int n_fail;

  // Model state per instance: index 0 keeps going, index 1 stops on failure.
  ent_t        mq      [2][$];
  int          m_pass  [2];
  int          m_failc [2];
  bit          m_failb [2];
  bit          m_orph  [2];
  bit          m_stop  [2];
  logic [63:0] m_cexp  [2];
  logic [63:0] m_cres  [2];
  logic [4:0]  m_cfd   [2];

  fp_result_scoreboard #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_WIDTH(CW), .STOP_ON_FAIL(1'b0)) u_dut_go (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_exp_valid(exp_vld), .o_exp_ready(rdy[0]), .i_exp_result(exp_res), .i_exp_flags(exp_flg),
    .i_exp_fmt(exp_fmt), .i_exp_relax(exp_relax), .i_exp_last(exp_last),
    .i_dut_ready(dut_rdy), .i_dut_result(dut_res), .i_dut_flags(dut_flg),
    .o_pass_count(pass_c[0]), .o_fail_count(fail_c[0]), .o_fail(failb[0]), .o_orphan(orph[0]),
    .o_done(done[0]), .o_cap_expected(cap_exp[0]), .o_cap_result(cap_res[0]),
    .o_cap_flags_diff(cap_fd[0]), .o_level(lvl[0]));

  fp_result_scoreboard #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_WIDTH(CW), .STOP_ON_FAIL(1'b1)) u_dut_halt (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_exp_valid(exp_vld), .o_exp_ready(rdy[1]), .i_exp_result(exp_res), .i_exp_flags(exp_flg),
    .i_exp_fmt(exp_fmt), .i_exp_relax(exp_relax), .i_exp_last(exp_last),
    .i_dut_ready(dut_rdy), .i_dut_result(dut_res), .i_dut_flags(dut_flg),
    .o_pass_count(pass_c[1]), .o_fail_count(fail_c[1]), .o_fail(failb[1]), .o_orphan(orph[1]),
    .o_done(done[1]), .o_cap_expected(cap_exp[1]), .o_cap_result(cap_res[1]),
    .o_cap_flags_diff(cap_fd[1]), .o_level(lvl[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Match rule from the result semantics: a canonical quiet NaN from the unit only has to
  // agree with the expected value on the exponent field and the quiet bit.
  function automatic bit ent_match(ent_t e, logic [63:0] r, logic [4:0] f);
    if (f != e.flg) return 1'b0;
    if (e.fmt == 2'd0) begin
      if (e.relax && r[31:0] == 32'h7FC0_0000)
        return (r[30:23] == e.res[30:23]) && (r[22] == e.res[22]);
      return r == e.res;
    end
    if (e.relax && r == 64'h7FF8_0000_0000_0000)
      return (r[62:52] == e.res[62:52]) && (r[51] == e.res[51]);
    return r == e.res;
  endfunction

  task automatic model_fail(int k, logic [63:0] e_res, logic [4:0] fd);
    if (m_failc[k] < CMAX) m_failc[k]++;
    if (!m_failb[k]) begin
      m_cexp[k] = e_res;
      m_cres[k] = dut_res;
      m_cfd[k]  = fd;
    end
    m_failb[k] = 1'b1;
    if (k == 1) m_stop[k] = 1'b1;
  endtask

  task automatic model_step(int k);
    bit   chkd, pop, push;
    int   sz;
    ent_t e;
    ent_t ne;
    sz   = mq[k].size();
    chkd = dut_rdy && !m_stop[k];
    pop  = chkd && sz > 0;
    push = exp_vld && !m_stop[k] && (sz < DEPTH || pop);
    ne   = '{res: exp_res, flg: exp_flg, fmt: exp_fmt, relax: exp_relax, last: exp_last};
    if (pop) begin
      e = mq[k].pop_front();
      if (ent_match(e, dut_res, dut_flg)) begin
        if (m_pass[k] < CMAX) m_pass[k]++;
      end else begin
        model_fail(k, e.res, dut_flg ^ e.flg);
      end
      if (e.last) m_stop[k] = 1'b1;
    end else if (chkd) begin
      m_orph[k] = 1'b1;
      model_fail(k, 64'd0, dut_flg);
    end
    if (push) mq[k].push_back(ne);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_pass[k] = 0; m_failc[k] = 0; m_failb[k] = 0; m_orph[k] = 0; m_stop[k] = 0;
      m_cexp[k] = '0; m_cres[k] = '0; m_cfd[k] = '0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("i%0d_level", k), lvl[k], mq[k].size());
      chk($sformatf("i%0d_exp_ready", k), rdy[k], (!m_stop[k] && mq[k].size() < DEPTH));
      chk($sformatf("i%0d_pass_count", k), pass_c[k], m_pass[k]);
      chk($sformatf("i%0d_fail_count", k), fail_c[k], m_failc[k]);
      chk($sformatf("i%0d_fail", k), failb[k], m_failb[k]);
      chk($sformatf("i%0d_orphan", k), orph[k], m_orph[k]);
      chk($sformatf("i%0d_done", k), done[k], m_stop[k]);
      chk($sformatf("i%0d_cap_expected", k), cap_exp[k], m_cexp[k]);
      chk($sformatf("i%0d_cap_result", k), cap_res[k], m_cres[k]);
      chk($sformatf("i%0d_cap_flags_diff", k), cap_fd[k], m_cfd[k]);
    end
  endtask

  task automatic idle();
    exp_vld = 0; exp_res = '0; exp_flg = '0; exp_fmt = '0; exp_relax = 0; exp_last = 0;
    dut_rdy = 0; dut_res = '0; dut_flg = '0;
  endtask

  task automatic push_set(logic [63:0] r, logic [4:0] f, logic [1:0] fm, logic rl, logic ls);
    exp_vld = 1; exp_res = r; exp_flg = f; exp_fmt = fm; exp_relax = rl; exp_last = ls;
  endtask

  task automatic dut_set(logic [63:0] r, logic [4:0] f);
    dut_rdy = 1; dut_res = r; dut_flg = f;
  endtask

  // Called #1 after a rising edge: apply the model to the current inputs, clock, check.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  // Reset lands between edges; its effect must be visible before the next edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [63:0] r;
    ent_t        h;
    n_checks = 0;
    n_fail   = 0;
    model_clear();
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // Three single-precision vectors returned four cycles after issue
    for (int i = 0; i < 3; i++) begin
      push_set(64'h3F80_0000, 5'd0, 2'd0, 1'b1, i == 2);
      tick();
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      dut_set(64'h3F80_0000, 5'd0);
      tick();
    end
    chk("t1_pass", pass_c[1], 3);
    chk("t1_done", done[1], 1);
    chk("t1_fail", failb[1], 0);
    do_reset();

    // Single canonical NaN: relaxed passes, strict fails
    push_set(64'h7FC0_0001, 5'd0, 2'd0, 1'b1, 1'b0); tick();
    push_set(64'h7FC0_0001, 5'd0, 2'd0, 1'b0, 1'b0); tick();
    dut_set(64'h7FC0_0000, 5'd0); tick();
    chk("t2_relax_pass", pass_c[0], 1);
    dut_set(64'h7FC0_0000, 5'd0); tick();
    chk("t2_strict_fail", failb[0], 1);
    chk("t2_cap_result", cap_res[0], 64'h7FC0_0000);
    do_reset();

    // Double canonical NaN, then a flag-only mismatch
    push_set(64'h7FF8_0000_0000_0001, 5'd0, 2'd1, 1'b1, 1'b0); tick();
    push_set(64'h7FF8_0000_0000_0001, 5'd0, 2'd1, 1'b1, 1'b0); tick();
    dut_set(64'h7FF8_0000_0000_0000, 5'd0); tick();
    chk("t3_relax_pass", pass_c[1], 1);
    dut_set(64'h7FF8_0000_0000_0000, 5'b10000); tick();
    chk("t3_cap_flags_diff", cap_fd[1], 5'b10000);
    do_reset();

    // Fill, then push+pop at full across the pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      push_set(64'h1000 + i, 5'd0, 2'd1, 1'b0, 1'b0);
      tick();
    end
    chk("t4_level_full", lvl[0], DEPTH);
    chk("t4_ready_full", rdy[0], 0);
    for (int i = 0; i < 12; i++) begin
      push_set(64'h2000 + i, 5'd0, 2'd1, 1'b0, 1'b0);
      dut_set(mq[0][0].res, 5'd0);
      tick();
    end
    chk("t4_level_hold", lvl[1], DEPTH);
    chk("t4_pass_order", pass_c[1], 12);
    do_reset();

    // Orphan result: halting instance stops, the other keeps counting
    dut_set(64'hDEAD, 5'd0); tick();
    chk("t5_orphan", orph[1], 1);
    chk("t5_fail_count", fail_c[1], 1);
    chk("t5_halt_done", done[1], 1);
    chk("t5_go_not_done", done[0], 0);
    push_set(64'h55, 5'd3, 2'd1, 1'b0, 1'b0); tick();
    tick();
    dut_set(64'h55, 5'd3); tick();
    chk("t5_go_pass", pass_c[0], 1);
    chk("t5_halt_ignored", pass_c[1], 0);
    do_reset();

    // Randomised rounds, each ended by a reset
    for (int round = 0; round < 4; round++) begin
      for (int c = 0; c < 100; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          r = {$urandom, $urandom};
          exp_fmt = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'd0;
          if ($urandom_range(0, 2) == 0) begin
            if (exp_fmt == 2'd0) r[31:0] = 32'h7FC0_0000 | ($urandom & 32'h003F_FFFF);
            else r = 64'h7FF8_0000_0000_0000 | ({$urandom, $urandom} & 64'h0007_FFFF_FFFF_FFFF);
          end
          push_set(r, 5'($urandom), exp_fmt, 1'($urandom), $urandom_range(0, 40) == 0);
        end
        if ($urandom_range(0, 2) == 0) begin
          if (mq[0].size() > 0) begin
            h = mq[0][0];
            case ($urandom_range(0, 4))
              0, 1: dut_set(h.res, h.flg);
              2: dut_set((h.fmt == 2'd0) ? {$urandom, 32'h7FC0_0000} : 64'h7FF8_0000_0000_0000, h.flg);
              3: dut_set(h.res ^ (64'd1 << $urandom_range(0, 63)), h.flg);
              default: dut_set(h.res, h.flg ^ 5'($urandom_range(1, 31)));
            endcase
          end else begin
            dut_set({$urandom, $urandom}, 5'($urandom));
          end
        end
        tick();
      end
      do_reset();
    end

    // Reset mid-stream with five entries still queued
    for (int i = 0; i < 6; i++) begin
      push_set(64'h300 + i, 5'd0, 2'd1, 1'b0, 1'b0);
      if (i == 5) dut_set(64'h300, 5'd0);
      tick();
    end
    chk("t6_level_before", lvl[0], 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_level", lvl[0], 0);
    chk("t6_async_pass", pass_c[0], 0);
    chk("t6_async_ready", rdy[0], 1);
    model_clear();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
